// File: rtl/bf_pkg.sv
// Shared defaults, weight-select encodings and controller state encodings for the beamformer weight path.
package bf_pkg;

  localparam int unsigned NCH_DEF     = 8;
  localparam int unsigned WW_DEF      = 5;
  localparam int unsigned TIMEOUT_DEF = 32;
  localparam int unsigned NSEL        = 4;
  localparam int unsigned CHW         = 3;
  localparam int unsigned SELW        = 2;

  typedef enum logic [SELW-1:0] {
    SEL_COS1 = 2'd0,
    SEL_SIN1 = 2'd1,
    SEL_COS2 = 2'd2,
    SEL_SIN2 = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

endpackage

// File: rtl/bf_weight_bank.sv
// 4 x NCH weight register array: one single-weight write port plus a full-width parallel load.
module bf_weight_bank
  import bf_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned WW  = WW_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [SELW-1:0]         wsel,
  input  logic [CHW-1:0]          wchan,
  input  logic [WW-1:0]           wdata,
  input  logic                    ld,
  input  logic [NSEL*NCH*WW-1:0]  ld_data,
  output logic [NSEL*NCH*WW-1:0]  q
);

  logic [NSEL*NCH*WW-1:0] bank_d, bank_q;

  // Parallel load wins over a single write; out-of-range channels are dropped.
  always_comb begin
    bank_d = bank_q;
    if (ld) begin
      bank_d = ld_data;
    end else if (we && (32'(wchan) < NCH)) begin
      bank_d[(32'(wsel) * NCH + 32'(wchan)) * WW +: WW] = wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bank_q <= '0;
    else        bank_q <= bank_d;
  end

  assign q = bank_q;

endmodule

// File: rtl/bf_weight_ctrl.sv
// Double-buffered weight scheduler: host writes a shadow bank, commit swaps it into the active bank on a
// sample strobe (or after TIMEOUT clocks). Optional BF_WCTRL_CLAMP_EN maps the most-negative code to -(2^(WW-1)-1).
module bf_weight_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned WW      = WW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_stb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CHW-1:0]    cmd_chan,
  input  logic [SELW-1:0]   cmd_sel,
  input  logic [WW-1:0]     cmd_data,
  input  logic              commit,
  output logic              busy,
  output logic              commit_done,
  output logic              timeout_err,
  output logic [NCH*WW-1:0] w_cos_1,
  output logic [NCH*WW-1:0] w_sin_1,
  output logic [NCH*WW-1:0] w_cos_2,
  output logic [NCH*WW-1:0] w_sin_2
);

  localparam int unsigned CNTW = $clog2(TIMEOUT);
  localparam int unsigned BUSW = NCH * WW;

  state_e            state_d, state_q;
  logic [CNTW-1:0]   wait_cnt_d, wait_cnt_q;
  logic              cmd_ready_d, cmd_ready_q;
  logic              busy_d, busy_q;
  logic              commit_done_d, commit_done_q;
  logic              timeout_err_d, timeout_err_q;
  logic              wr_en, timeout_hit, swap;
  logic [WW-1:0]     wdata;
  logic [NSEL*BUSW-1:0] shadow_w, active_w;

  assign wr_en       = cmd_valid & cmd_ready_q;
  assign timeout_hit = (wait_cnt_q == CNTW'(TIMEOUT - 1));

  always_comb begin
    wdata = cmd_data;
`ifdef BF_WCTRL_CLAMP_EN
    if (cmd_data == {1'b1, {(WW-1){1'b0}}}) wdata = {1'b1, {(WW-2){1'b0}}, 1'b1};
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next state and wait counter; the counter only runs while armed.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (commit)     state_d = ST_ARMED;
        else if (wr_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (commit) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        wait_cnt_d = wait_cnt_q + CNTW'(1);
        if (sample_stb || timeout_hit) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Registered flag outputs and the swap strobe; a strobe coinciding with the timeout is a normal swap.
  always_comb begin
    swap          = (state_q == ST_ARMED) && (sample_stb || timeout_hit);
    commit_done_d = swap;
    timeout_err_d = timeout_err_q | ((state_q == ST_ARMED) && timeout_hit && !sample_stb);
    cmd_ready_d   = (state_d != ST_ARMED);
    busy_d        = (state_d == ST_ARMED);
  end

  bf_weight_bank #(.NCH(NCH), .WW(WW)) u_shadow (
    .clock   (clock),
    .reset   (reset),
    .we      (wr_en),
    .wsel    (cmd_sel),
    .wchan   (cmd_chan),
    .wdata   (wdata),
    .ld      (1'b0),
    .ld_data ('0),
    .q       (shadow_w)
  );

  bf_weight_bank #(.NCH(NCH), .WW(WW)) u_active (
    .clock   (clock),
    .reset   (reset),
    .we      (1'b0),
    .wsel    ('0),
    .wchan   ('0),
    .wdata   ('0),
    .ld      (swap),
    .ld_data (shadow_w),
    .q       (active_w)
  );

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign timeout_err = timeout_err_q;
  assign w_cos_1     = active_w[32'(SEL_COS1) * BUSW +: BUSW];
  assign w_sin_1     = active_w[32'(SEL_SIN1) * BUSW +: BUSW];
  assign w_cos_2     = active_w[32'(SEL_COS2) * BUSW +: BUSW];
  assign w_sin_2     = active_w[32'(SEL_SIN2) * BUSW +: BUSW];

endmodule

// File: tb/tb_bf_weight_ctrl.sv
// Bench for bf_weight_ctrl: directed scenarios plus random traffic against a behavioural bank model.
module tb_bf_weight_ctrl;

  localparam int unsigned NCH     = 8;
  localparam int unsigned WW      = 5;
  localparam int unsigned TIMEOUT = 32;

  logic clock, reset;
  logic sample_stb, cmd_valid, cmd_ready, commit, busy, commit_done, timeout_err;
  logic [2:0] cmd_chan;
  logic [1:0] cmd_sel;
  logic [WW-1:0] cmd_data;
  logic [NCH*WW-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;

  int checks = 0;
  int errors = 0;

  bf_weight_ctrl #(.NCH(NCH), .WW(WW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .sample_stb(sample_stb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data), .commit(commit),
    .busy(busy), .commit_done(commit_done), .timeout_err(timeout_err),
    .w_cos_1(w_cos_1), .w_sin_1(w_sin_1), .w_cos_2(w_cos_2), .w_sin_2(w_sin_2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two arrays of weights, an armed flag and a count of clocks spent armed.
  logic [WW-1:0] m_sh  [4][NCH];
  logic [WW-1:0] m_act [4][NCH];
  bit m_armed, m_done, m_terr;
  int m_wait;

  function automatic logic [WW-1:0] clamp(input logic [WW-1:0] d);
`ifdef BF_WCTRL_CLAMP_EN
    if (d == 5'b10000) return 5'b10001;
`endif
    return d;
  endfunction

  function automatic logic [NCH*WW-1:0] pack(input int s);
    logic [NCH*WW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*WW +: WW] = m_act[s][k];
    return v;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 4; s++)
        for (int k = 0; k < NCH; k++) begin
          m_sh[s][k]  <= '0;
          m_act[s][k] <= '0;
        end
      m_armed <= 0; m_done <= 0; m_terr <= 0; m_wait <= 0;
    end else begin
      m_done <= 0;
      if (m_armed) begin
        if (sample_stb || m_wait == TIMEOUT - 1) begin
          m_act   <= m_sh;
          m_done  <= 1;
          m_armed <= 0;
          m_wait  <= 0;
          if (!sample_stb) m_terr <= 1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        if (cmd_valid && int'(cmd_chan) < NCH) m_sh[cmd_sel][cmd_chan] <= clamp(cmd_data);
        if (commit) begin
          m_armed <= 1;
          m_wait  <= 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("w_cos_1", 64'(w_cos_1), 64'(pack(0)));
    chk("w_sin_1", 64'(w_sin_1), 64'(pack(1)));
    chk("w_cos_2", 64'(w_cos_2), 64'(pack(2)));
    chk("w_sin_2", 64'(w_sin_2), 64'(pack(3)));
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_armed));
    chk("busy", 64'(busy), 64'(m_armed));
    chk("commit_done", 64'(commit_done), 64'(m_done));
    chk("timeout_err", 64'(timeout_err), 64'(m_terr));
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wr(input int ch, input int sel, input logic [WW-1:0] d);
    cmd_valid = 1; cmd_chan = 3'(ch); cmd_sel = 2'(sel); cmd_data = d;
    tick();
    cmd_valid = 0;
  endtask

  task automatic pulse_commit();
    commit = 1;
    tick();
    commit = 0;
  endtask

  task automatic pulse_stb();
    sample_stb = 1;
    tick();
    sample_stb = 0;
  endtask

  int done_cnt;
  int stb_pct;
  logic [WW-1:0] exp_clamp;

  initial begin
    reset = 0; sample_stb = 0; cmd_valid = 0; commit = 0;
    cmd_chan = 0; cmd_sel = 0; cmd_data = 0;

    // Reset held 20 clocks
    repeat (20) tick();
    chk("t1_cos1", 64'(w_cos_1), 64'd0);
    chk("t1_sin2", 64'(w_sin_2), 64'd0);
    chk("t1_ready", 64'(cmd_ready), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_terr", 64'(timeout_err), 64'd0);
    reset = 1;
    tick();

    // Basic write/commit/strobe swap
    wr(0, 0, 5'd15);
    wr(1, 1, 5'b10110);
    pulse_commit();
    tick();
    chk("t2_cos1_before", 64'(w_cos_1), 64'd0);
    chk("t2_sin1_before", 64'(w_sin_1), 64'd0);
    pulse_stb();
    chk("t2_cos1_ch0", 64'(w_cos_1[4:0]), 64'd15);
    chk("t2_sin1_ch1", 64'(w_sin_1[9:5]), 64'b10110);
    chk("t2_done", 64'(commit_done), 64'd1);
    tick();

    // Writes and commits while armed are ignored
    pulse_commit();
    cmd_valid = 1; cmd_chan = 3'd2; cmd_sel = 2'd0; cmd_data = 5'd7;
    tick();
    chk("t3_ready", 64'(cmd_ready), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    commit = 1;
    tick();
    commit = 0; cmd_valid = 0;
    sample_stb = 1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sample_stb = 0;
      done_cnt += int'(commit_done);
    end
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    chk("t3_cos1_ch2", 64'(w_cos_1[14:10]), 64'd0);

    // Forced swap after TIMEOUT, sticky error
    pulse_commit();
    repeat (40) tick();
    chk("t4_terr", 64'(timeout_err), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    pulse_commit();
    pulse_stb();
    chk("t4_terr_sticky", 64'(timeout_err), 64'd1);

    // Same-cycle write and commit
    cmd_valid = 1; cmd_chan = 3'd7; cmd_sel = 2'd2; cmd_data = 5'b10001; commit = 1;
    tick();
    cmd_valid = 0; commit = 0;
    tick();
    pulse_stb();
    chk("t5_cos2_ch7", 64'(w_cos_2[39:35]), 64'b10001);

    // Strobe coinciding with the timeout cycle is a normal swap
    reset = 0; tick(); reset = 1; tick();
    pulse_commit();
    repeat (31) tick();
    chk("t5_still_armed", 64'(busy), 64'd1);
    pulse_stb();
    chk("t5_terr_zero", 64'(timeout_err), 64'd0);
    chk("t5_done", 64'(commit_done), 64'd1);

    // Most-negative code handling
`ifdef BF_WCTRL_CLAMP_EN
    exp_clamp = 5'b10001;
`else
    exp_clamp = 5'b10000;
`endif
    wr(3, 3, 5'b10000);
    pulse_commit();
    pulse_stb();
    chk("t6_sin2_ch3", 64'(w_sin_2[19:15]), 64'(exp_clamp));

    // Asynchronous reset while armed
    pulse_commit();
    tick();
    chk("t6_armed", 64'(busy), 64'd1);
    #3 reset = 0;
    #1;
    chk("t6_rst_cos1", 64'(w_cos_1), 64'd0);
    chk("t6_rst_cos2", 64'(w_cos_2), 64'd0);
    chk("t6_rst_sin2", 64'(w_sin_2), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(cmd_ready), 64'd1);
    tick();
    reset = 1;
    tick();

    // Random traffic: alternating frequent and rare strobes to hit both swap kinds
    for (int ph = 0; ph < 6; ph++) begin
      stb_pct = (ph % 2 == 0) ? 15 : 1;
      for (int c = 0; c < 500; c++) begin
        cmd_valid  = ($urandom_range(0, 1) == 1);
        cmd_chan   = 3'($urandom_range(0, 7));
        cmd_sel    = 2'($urandom_range(0, 3));
        cmd_data   = ($urandom_range(0, 7) == 0) ? 5'b10000 : 5'($urandom);
        commit     = ($urandom_range(0, 99) < 8);
        sample_stb = ($urandom_range(0, 99) < stb_pct);
        tick();
      end
      if (ph == 3) begin
        #2 reset = 0;
        tick();
        reset = 1;
      end
    end
    cmd_valid = 0; commit = 0; sample_stb = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
